// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Each port has a valid/ready request handshake and a one-entry registered
// result slot with its own valid/ready response handshake. The ALU itself
// lives outside this block: we drive its operands and capture its result.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,

  output logic             grant_id
);

  logic             rrPtr_q;
  logic             rsp0Valid_q, rsp1Valid_q;
  logic [WIDTH-1:0] rsp0Data_q,  rsp1Data_q;

  logic             eligible0, eligible1;
  logic             grant0, grant1;

  // A port may issue when it has a request and its result slot is empty or
  // being drained this same cycle; the rr pointer breaks ties, and nothing
  // is granted while reset is held so no result can be produced then.
  always_comb begin
    eligible0 = req0_valid && (!rsp0Valid_q || rsp0_ready);
    eligible1 = req1_valid && (!rsp1Valid_q || rsp1_ready);
    grant0    = rst_n && eligible0 && (!eligible1 || !rrPtr_q);
    grant1    = rst_n && eligible1 && (!eligible0 ||  rrPtr_q);
  end

  // Handshake outputs and the ALU operand mux; idle cycles present port 0's
  // operands so the ALU never sees X.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    grant_id   = grant1;
    alu_a      = grant1 ? req1_a  : req0_a;
    alu_b      = grant1 ? req1_b  : req0_b;
    alu_op     = grant1 ? req1_op : req0_op;
  end

  // Round-robin pointer: after serving a port, the other port gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q <= 1'b0;
    end else if (grant0) begin
      rrPtr_q <= 1'b1;
    end else if (grant1) begin
      rrPtr_q <= 1'b0;
    end
  end

  // Port 0 result slot: a new accept overrides a drain so back-to-back
  // results stream at one per cycle; a plain drain keeps the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0Valid_q <= 1'b0;
      rsp0Data_q  <= '0;
    end else if (grant0) begin
      rsp0Valid_q <= 1'b1;
      rsp0Data_q  <= alu_res;
    end else if (rsp0Valid_q && rsp0_ready) begin
      rsp0Valid_q <= 1'b0;
    end
  end

  // Port 1 result slot, same behaviour as port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1Valid_q <= 1'b0;
      rsp1Data_q  <= '0;
    end else if (grant1) begin
      rsp1Valid_q <= 1'b1;
      rsp1Data_q  <= alu_res;
    end else if (rsp1Valid_q && rsp1_ready) begin
      rsp1Valid_q <= 1'b0;
    end
  end

  assign rsp0_valid = rsp0Valid_q;
  assign rsp0_data  = rsp0Data_q;
  assign rsp1_valid = rsp1Valid_q;
  assign rsp1_data  = rsp1Data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. A tiny behavioural ALU (add / sub / and)
// closes the loop so expected results can be hand-computed from operands.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [31:0] req0_a, req0_b, rsp0_data;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req1_a, req1_b, rsp1_data;
  logic [3:0]  req1_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        grant_id;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .grant_id(grant_id)
  );

  // Stand-in for the shared ALU.
  assign alu_res = (alu_op == 4'b1000) ? (alu_a - alu_b) :
                   (alu_op == 4'b0111) ? (alu_a & alu_b) :
                                         (alu_a + alu_b);

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] op0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic [3:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n0, n1, got0, got1;
    rst_n = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    applyStimulus(1'b1, 32'd7, 32'd3, 4'b0000, 1'b1, 32'd7, 32'd3, 4'b1000);

    // Reset state: nothing granted even with requests present.
    #3;
    checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("rst_rsp0_data", rsp0_data, 32'd0);
    checkOutput("rst_rsp1_data", rsp1_data, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    #9 rst_n = 1'b1;
    tick();

    // Single add on port 0.
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(1'b1, 32'h7, 32'h3, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    #1;
    checkOutput("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("add_req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("add_grant_id", {31'd0, grant_id}, 32'd0);
    checkOutput("add_alu_a", alu_a, 32'h7);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    checkOutput("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("add_rsp0_data", rsp0_data, 32'h0000000A);
    tick();
    checkOutput("add_rsp0_drop", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("add_rsp0_hold", rsp0_data, 32'h0000000A);

    // Wrap passthrough on port 1 (also hands priority back to port 0).
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'hFFFFFFFF, 32'h1, 4'b0000);
    #1;
    checkOutput("wrap_req1_ready", {31'd0, req1_ready}, 32'd1);
    checkOutput("wrap_grant_id", {31'd0, grant_id}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    checkOutput("wrap_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    checkOutput("wrap_rsp1_data", rsp1_data, 32'h00000000);
    tick();

    // Contention: port 0 first, then port 1.
    applyStimulus(1'b1, 32'd7, 32'd3, 4'b0000, 1'b1, 32'd7, 32'd3, 4'b1000);
    #1;
    checkOutput("cont_grant_first", {31'd0, grant_id}, 32'd0);
    checkOutput("cont_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("cont_req1_wait", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    checkOutput("cont_grant_second", {31'd0, grant_id}, 32'd1);
    checkOutput("cont_req1_ready", {31'd0, req1_ready}, 32'd1);
    checkOutput("cont_rsp0_data", rsp0_data, 32'h0000000A);
    checkOutput("cont_rsp1_not_yet", {31'd0, rsp1_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    checkOutput("cont_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    checkOutput("cont_rsp1_data", rsp1_data, 32'h00000004);
    checkOutput("cont_rsp0_drained", {31'd0, rsp0_valid}, 32'd0);
    tick();

    // Round-robin streaming, 8 cycles.
    n0 = 0; n1 = 0; got0 = 0; got1 = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, n0, 32'd100, 4'b0000, 1'b1, 32'd1000, n1, 4'b1000);
      #1;
      checkOutput($sformatf("rr_grant_%0d", k), {31'd0, grant_id}, k % 2);
      tick();
      if (rsp0_valid) got0++;
      if (rsp1_valid) got1++;
      if (k % 2 == 0) begin
        checkOutput($sformatf("rr_rsp0_data_%0d", k), rsp0_data, n0 + 100);
        n0++;
      end else begin
        checkOutput($sformatf("rr_rsp1_data_%0d", k), rsp1_data, 1000 - n1);
        n1++;
      end
    end
    checkOutput("rr_count0", got0, 32'd4);
    checkOutput("rr_count1", got1, 32'd4);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    tick();

    // Backpressure on port 1's result slot.
    rsp1_ready = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd5, 32'd2, 4'b1000);
    tick();
    checkOutput("bp_rsp1_first", rsp1_data, 32'd3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'd20 + k, 32'hF0, 4'b0111, 1'b1, 32'd9, 32'd4, 4'b1000);
      #1;
      checkOutput($sformatf("bp_req1_blocked_%0d", k), {31'd0, req1_ready}, 32'd0);
      checkOutput($sformatf("bp_req0_granted_%0d", k), {31'd0, req0_ready}, 32'd1);
      tick();
      checkOutput($sformatf("bp_rsp0_data_%0d", k), rsp0_data, (32'd20 + k) & 32'hF0);
      checkOutput($sformatf("bp_rsp1_held_%0d", k), {rsp1_data[30:0], rsp1_valid}, {31'd3, 1'b1});
    end
    rsp1_ready = 1'b1;
    #1;
    checkOutput("bp_req1_release", {31'd0, req1_ready}, 32'd1);
    checkOutput("bp_req0_yield", {31'd0, req0_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    checkOutput("bp_rsp1_second", rsp1_data, 32'd5);
    tick();

    // Asynchronous reset while port 0 holds an undrained result.
    rsp0_ready = 1'b0;
    applyStimulus(1'b1, 32'd7, 32'd3, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    tick();
    req0_valid = 1'b0;
    checkOutput("ar_rsp0_before", {31'd0, rsp0_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ar_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("ar_rsp0_data", rsp0_data, 32'd0);
    #1 rst_n = 1'b1;
    rsp0_ready = 1'b1;
    applyStimulus(1'b1, 32'd7, 32'd3, 4'b0000, 1'b1, 32'd7, 32'd3, 4'b1000);
    #1;
    checkOutput("ar_grant_after", {31'd0, grant_id}, 32'd0);
    checkOutput("ar_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    checkOutput("ar_rsp0_data_after", rsp0_data, 32'h0000000A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
